instr_mem_loader: RTL

// - Write side of the instruction memory. It receives a program image as a

---
 rtl/loader_pkg.sv | 28 ++
 rtl/instr_mem_loader_word_assembler.sv | 47 ++++
 rtl/instr_mem_loader.sv | 138 +++++++++++++
 3 files changed

// File: rtl/loader_pkg.sv
// ---------------------------------------------------------------------------
// loader_pkg
// Shared types and constants for the instruction-memory loader.
//   loader_state_t : frame-parser FSM states
//   SYNC_DEFAULT   : default frame start marker
//   WORD_BYTES     : stream bytes per instruction word
//   word_byte_addr : word index -> byte address as seen by the fetch port
// ---------------------------------------------------------------------------
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        COUNT,
        DATA,
        CHECK,
        DONE,
        ERR
    } loader_state_t;

    localparam logic [7:0] SYNC_DEFAULT = 8'h55;
    localparam int         WORD_BYTES   = 4;

    // The fetch port reads with a[31:2], so word k lives at byte address 4*k.
    function automatic logic [31:0] word_byte_addr(input logic [7:0] idx);
        return {22'd0, idx, 2'b00};
    endfunction

endpackage

// File: rtl/instr_mem_loader_word_assembler.sv
// ---------------------------------------------------------------------------
// word_assembler
// Packs consecutive stream bytes (MSB first) into a 32-bit instruction word.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   clear        : start of a new frame, discards any partial word
//   shift_en     : accepted data byte on in_data this cycle
//   in_data      : stream byte
//   word         : completed word, valid in the cycle word_ready is high
//   word_ready   : this shift supplies the 4th byte of a word
// ---------------------------------------------------------------------------
module word_assembler
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        shift_en,
    input  logic [7:0]  in_data,
    output logic [31:0] word,
    output logic        word_ready
);

    // Only the three earlier bytes need storing; the 4th is taken straight
    // from in_data so the word is complete in the same cycle it arrives.
    logic [23:0] shift_q;
    logic [1:0]  byte_cnt;

    assign word       = {shift_q, in_data};
    assign word_ready = shift_en && (byte_cnt == 2'(WORD_BYTES - 1));

    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples the values from before the edge, regardless of order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_q  <= '0;
            byte_cnt <= '0;
        end else if (clear) begin
            shift_q  <= '0;
            byte_cnt <= '0;
        end else if (shift_en) begin
            shift_q  <= {shift_q[15:0], in_data};
            byte_cnt <= byte_cnt + 2'd1;    // wraps to 0 after the 4th byte
        end
    end

endmodule

// File: rtl/instr_mem_loader.sv
// ---------------------------------------------------------------------------
// instr_mem_loader
// Write side of the instruction RAM. Parses a framed byte stream
// (SYNC, N, 4*N data bytes MSB first, XOR checksum), writes each word to
// RAM and holds the CPU until the checksum of a complete image verifies.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   in_valid     : byte available on in_data
//   in_data      : stream byte
//   in_ready     : always 1, one byte consumed per transfer
//   we           : one-cycle RAM write strobe
//   waddr        : RAM byte address {word_idx, 2'b00}
//   wdata        : assembled instruction word
//   cpu_hold     : keep processor stalled while an image is loading / bad
//   done         : last frame loaded and verified (sticky until next sync)
//   error        : last frame rejected (sticky until next sync)
// ---------------------------------------------------------------------------
module instr_mem_loader
    import loader_pkg::*;
#(
    parameter int         DEPTH     = 64,
    parameter logic [7:0] SYNC_BYTE = SYNC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        we,
    output logic [31:0] waddr,
    output logic [31:0] wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);

    localparam logic [7:0] DEPTH_B = 8'(DEPTH);

    loader_state_t state;
    logic [7:0]    n_words;
    logic [7:0]    word_idx;
    logic [7:0]    csum;

    logic          xfer;
    logic          sync_seen;
    logic          asm_clear;
    logic          asm_shift;
    logic [31:0]   asm_word;
    logic          asm_ready;

    assign in_ready  = 1'b1;
    assign xfer      = in_valid && in_ready;
    assign sync_seen = xfer && (in_data == SYNC_BYTE);

    // A sync only starts a frame outside one; inside a frame it is plain data.
    assign asm_clear = sync_seen && (state == IDLE || state == DONE || state == ERR);
    assign asm_shift = xfer && (state == DATA);

    word_assembler u_word_assembler (
        .clk        (clk),
        .reset      (reset),
        .clear      (asm_clear),
        .shift_en   (asm_shift),
        .in_data    (in_data),
        .word       (asm_word),
        .word_ready (asm_ready)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            n_words  <= '0;
            word_idx <= '0;
            csum     <= '0;
            we       <= 1'b0;
            waddr    <= '0;
            wdata    <= '0;
            cpu_hold <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
        end else begin
            we <= 1'b0;    // strobe lasts exactly one cycle
            unique case (state)
                IDLE, DONE, ERR: begin
                    if (sync_seen) begin
                        state    <= COUNT;
                        cpu_hold <= 1'b1;
                        done     <= 1'b0;
                        error    <= 1'b0;
                        word_idx <= '0;
                        csum     <= '0;
                    end
                end
                COUNT: begin
                    if (xfer) begin
                        // Rejecting N > DEPTH here is what keeps waddr in range.
                        if (in_data == 8'd0 || in_data > DEPTH_B) begin
                            state <= ERR;
                            error <= 1'b1;
                        end else begin
                            n_words <= in_data;
                            state   <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (xfer) begin
                        csum <= csum ^ in_data;
                        if (asm_ready) begin
                            // Registered strobe: one cycle after the 4th byte.
                            we       <= 1'b1;
                            wdata    <= asm_word;
                            waddr    <= word_byte_addr(word_idx);
                            word_idx <= word_idx + 8'd1;
                            if (word_idx == n_words - 8'd1) begin
                                state <= CHECK;
                            end
                        end
                    end
                end
                CHECK: begin
                    if (xfer) begin
                        if (in_data == csum) begin
                            state    <= DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            state <= ERR;
                            error <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
